// File: rtl/control_fetch.sv
// Instruction-fetch sequencer: jumps the PC to an algorithm base, fills the ROM, then free-runs
// until HALT or abort. Optional watchdog enabled by defining CONTROL_FETCH_WDT_EN.
module control_fetch #(
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned MAX_INSTR   = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alg_sel,
  input  logic             stall,
  input  logic             abort,
  input  logic [3:0]       opcode,
  output logic [2:0]       sel_dir,
  output logic             sel_pc,
  output logic             if_en,
  output logic             instr_valid,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {StIdle, StJump, StFill, StRun, StDone} state_e;

  state_e           state_q;
  logic [2:0]       sel_dir_q;
  logic             sel_pc_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic [CNT_W-1:0] count_q;
  logic             wdt_hit;

  // if_en and instr_valid must react to stall/abort/opcode in the same cycle.
  always_comb begin
    if_en       = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      StJump, StFill: if_en = ~abort;
      StRun: begin
        if (!abort && !stall && (opcode != HALT_OPCODE)) begin
          if_en       = 1'b1;
          instr_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef CONTROL_FETCH_WDT_EN
  assign wdt_hit = instr_valid && (count_q == CNT_W'(MAX_INSTR - 1));
`else
  logic [31:0] unused_max_instr;
  assign unused_max_instr = 32'(MAX_INSTR);
  assign wdt_hit          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_dir_q <= '0;
      sel_pc_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      sel_pc_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            sel_dir_q <= alg_sel;
            count_q   <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b1;
            sel_pc_q  <= 1'b1;
            state_q   <= StJump;
          end
        end
        StJump, StFill: begin
          if (abort) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= (state_q == StJump) ? StFill : StRun;
          end
        end
        StRun: begin
          if (abort) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (!stall) begin
            if (opcode == HALT_OPCODE) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              count_q <= count_q + 1'b1;
              if (wdt_hit) begin
                error_q <= 1'b1;
                done_q  <= 1'b1;
                state_q <= StDone;
              end
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sel_dir     = sel_dir_q;
  assign sel_pc      = sel_pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_fetch.sv
// Directed bench for control_fetch with a small PC + synchronous ROM model of the IF stage.
module tb_control_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stall, abort;
  logic [2:0] alg_sel;
  logic [3:0] opcode;
  logic [2:0] sel_dir;
  logic       sel_pc, if_en, instr_valid, busy, done, error;
  logic [9:0] instr_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] rom [0:1023];
  logic [9:0] pc;
  logic [3:0] rom_q;

  always #5 clk = ~clk;

  control_fetch #(.MAX_INSTR(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alg_sel     (alg_sel),
    .stall       (stall),
    .abort       (abort),
    .opcode      (opcode),
    .sel_dir     (sel_dir),
    .sel_pc      (sel_pc),
    .if_en       (if_en),
    .instr_valid (instr_valid),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .instr_count (instr_count)
  );

  // IF stage: base(k) = k*128, ROM output appears one cycle after its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      rom_q <= '0;
    end else if (if_en) begin
      pc    <= sel_pc ? {sel_dir, 7'd0} : pc + 10'd1;
      rom_q <= rom[pc];
    end
  end
  assign opcode = rom_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, let combinational outputs settle.
  task automatic drive(input logic st, input logic [2:0] sel, input logic stl, input logic ab);
    @(posedge clk);
    #2;
    start   = st;
    alg_sel = sel;
    stall   = stl;
    abort   = ab;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 4'h0;
    for (int i = 0; i < 5; i++) rom[384 + i] = 4'(i + 1);
    rom[389] = 4'hF;
    for (int i = 0; i < 10; i++) rom[128 + i] = 4'(i + 1);
    rom[138] = 4'hF;

    rst_n = 1'b0; start = 1'b0; alg_sel = 3'd0; stall = 1'b0; abort = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_if_en", if_en, 0);
    check_eq("rst_sel_pc", sel_pc, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_count", instr_count, 0);
    check_eq("rst_sel_dir", sel_dir, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic run, alg 3: 5 issues then HALT.
    drive(1, 3, 0, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_if_en", if_en, 0);
    drive(0, 0, 0, 0);
    check_eq("jump_sel_dir", sel_dir, 3);
    check_eq("jump_sel_pc", sel_pc, 1);
    check_eq("jump_if_en", if_en, 1);
    check_eq("jump_busy", busy, 1);
    check_eq("jump_iv", instr_valid, 0);
    drive(0, 0, 0, 0);
    check_eq("fill_sel_pc", sel_pc, 0);
    check_eq("fill_if_en", if_en, 1);
    check_eq("fill_iv", instr_valid, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0);
      check_eq("run_iv", instr_valid, 1);
      check_eq("run_opcode", opcode, i + 1);
      check_eq("run_count", instr_count, i);
    end
    drive(0, 0, 0, 0);
    check_eq("halt_iv", instr_valid, 0);
    check_eq("halt_if_en", if_en, 0);
    check_eq("halt_done", done, 0);
    check_eq("halt_count", instr_count, 5);
    drive(0, 0, 0, 0);
    check_eq("done_pulse", done, 1);
    check_eq("done_busy", busy, 1);
    check_eq("done_count", instr_count, 5);
    drive(0, 0, 0, 0);
    check_eq("post_done", done, 0);
    check_eq("post_busy", busy, 0);

    // Stall mid-run and stall over HALT, alg 1.
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0);
      check_eq("pre_stall_iv", instr_valid, 1);
      check_eq("pre_stall_op", opcode, i + 1);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0);
      check_eq("stall_if_en", if_en, 0);
      check_eq("stall_iv", instr_valid, 0);
      check_eq("stall_op", opcode, 3);
      check_eq("stall_count", instr_count, 2);
    end
    for (int i = 2; i < 10; i++) begin
      drive(0, 0, 0, 0);
      check_eq("resume_iv", instr_valid, 1);
      check_eq("resume_op", opcode, i + 1);
      check_eq("resume_count", instr_count, i);
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 0);
      check_eq("stall_halt_iv", instr_valid, 0);
      check_eq("stall_halt_done", done, 0);
      check_eq("stall_halt_busy", busy, 1);
    end
    drive(0, 0, 0, 0);
    check_eq("halt2_iv", instr_valid, 0);
    check_eq("halt2_done", done, 0);
    drive(0, 0, 0, 0);
    check_eq("halt2_done_pulse", done, 1);
    check_eq("halt2_count", instr_count, 10);
    drive(0, 0, 0, 0);
    check_eq("halt2_idle", busy, 0);

    // Abort at count 2, start while busy ignored, alg 5 (no HALT).
    drive(1, 5, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check_eq("ab_count0", instr_count, 0);
    drive(1, 6, 0, 0);
    check_eq("ab_iv", instr_valid, 1);
    drive(1, 6, 0, 1);
    check_eq("ab_cycle_iv", instr_valid, 0);
    check_eq("ab_cycle_count", instr_count, 2);
    drive(0, 0, 0, 0);
    check_eq("ab_done", done, 1);
    check_eq("ab_done_count", instr_count, 2);
    check_eq("ab_sel_dir", sel_dir, 5);
    check_eq("ab_error", error, 0);
    drive(0, 0, 0, 0);
    check_eq("ab_idle_busy", busy, 0);
    check_eq("ab_idle_sel_dir", sel_dir, 5);

    // Abort in IDLE does nothing; start+abort in IDLE starts, abort in JUMP ends.
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    check_eq("idle_ab_busy", busy, 0);
    check_eq("idle_ab_done", done, 0);
    drive(1, 2, 0, 1);
    drive(0, 0, 0, 1);
    check_eq("sa_sel_pc", sel_pc, 1);
    check_eq("sa_sel_dir", sel_dir, 2);
    check_eq("sa_iv", instr_valid, 0);
    drive(0, 0, 0, 0);
    check_eq("sa_done", done, 1);
    check_eq("sa_count", instr_count, 0);
    drive(0, 0, 0, 0);
    check_eq("sa_idle", busy, 0);

`ifdef CONTROL_FETCH_WDT_EN
    drive(1, 5, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0);
      check_eq("wdt_iv", instr_valid, 1);
      check_eq("wdt_count", instr_count, i);
    end
    drive(0, 0, 0, 0);
    check_eq("wdt_done", done, 1);
    check_eq("wdt_error", error, 1);
    check_eq("wdt_final_count", instr_count, 8);
    drive(0, 0, 0, 0);
    check_eq("wdt_error_hold", error, 1);
    drive(1, 3, 0, 0);
    drive(0, 0, 0, 0);
    check_eq("wdt_error_clr", error, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
`else
    drive(1, 5, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0);
      check_eq("nowdt_iv", instr_valid, 1);
      check_eq("nowdt_error", error, 0);
    end
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    check_eq("nowdt_done", done, 1);
    check_eq("nowdt_count", instr_count, 10);
    drive(0, 0, 0, 0);
`endif

    // Mid-run asynchronous reset.
    drive(1, 3, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_if_en", if_en, 0);
    check_eq("mid_rst_iv", instr_valid, 0);
    check_eq("mid_rst_count", instr_count, 0);
    check_eq("mid_rst_sel_dir", sel_dir, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_sel_pc", sel_pc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
